// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with an iterative shift-add multiplier.
// Single-cycle ops (ADD, SUB, BGE, SLL, SRL, AND, OR) finish in one cycle.
// MUL steps MUL_STEP multiplier bits per BUSY cycle.
// Optional feature macro: ALU_FLAGS_EN adds registered flag_zero / flag_carry outputs.
module alu_seq #(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
`ifdef ALU_FLAGS_EN
   ,
   output logic             flag_zero,
   output logic             flag_carry
`endif
);

   localparam int STEPS = WIDTH / MUL_STEP;
   localparam int CW    = $clog2(STEPS) + 1;
   localparam int SW    = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_MUL = 3'd1;
   localparam logic [2:0] OP_BGE = 3'd2;
   localparam logic [2:0] OP_SLL = 3'd3;
   localparam logic [2:0] OP_SUB = 3'd4;
   localparam logic [2:0] OP_SRL = 3'd5;
   localparam logic [2:0] OP_AND = 3'd6;
   localparam logic [2:0] OP_OR  = 3'd7;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, mcand, mplier;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] digit, acc_nxt, alu_res;
   logic             accept, is_mul;

   // Result of every single-cycle op; MUL is handled by the iterative engine.
   function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] o,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      r = '0;
      case (o)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_BGE:  r = {{(WIDTH-1){1'b0}}, (a >= b)};
         OP_SLL:  r = a << b[SW-1:0];
         OP_SRL:  r = a >> b[SW-1:0];
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         default: r = '0;
      endcase
      return r;
   endfunction

`ifdef ALU_FLAGS_EN
   // Carry-out of ADD, borrow of SUB, zero otherwise.
   function automatic logic carry_f(input logic [2:0] o,
                                    input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      case (o)
         OP_ADD:  carry_f = s[WIDTH];
         OP_SUB:  carry_f = (a < b);
         default: carry_f = 1'b0;
      endcase
   endfunction
`endif

   assign accept    = in_valid & in_ready;
   assign is_mul    = (op == OP_MUL);
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == BUSY);
   assign alu_res   = alu_f(op, src1, src2);
   assign digit     = WIDTH'(mplier[MUL_STEP-1:0]);
   assign acc_nxt   = acc + mcand * digit;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode: DONE holds until the consumer drains it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = is_mul ? BUSY : DONE;
         BUSY: if (cnt == '0) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture on accept, shift-add iteration while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
`ifdef ALU_FLAGS_EN
         flag_zero  <= 1'b0;
         flag_carry <= 1'b0;
`endif
      end else if (accept) begin
         if (is_mul) begin
            acc    <= '0;
            mcand  <= src1;
            mplier <= src2;
            cnt    <= CW'(STEPS - 1);
         end else begin
            result <= alu_res;
`ifdef ALU_FLAGS_EN
            flag_zero  <= (alu_res == '0);
            flag_carry <= carry_f(op, src1, src2);
`endif
         end
      end else if (state == BUSY) begin
         acc    <= acc_nxt;
         mcand  <= mcand << MUL_STEP;
         mplier <= mplier >> MUL_STEP;
         cnt    <= cnt - 1'b1;
         if (cnt == '0) begin
            result <= acc_nxt;
`ifdef ALU_FLAGS_EN
            flag_zero  <= (acc_nxt == '0);
            flag_carry <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (default WIDTH=32, MUL_STEP=1, plus a MUL_STEP=4 instance).
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [2:0]  op;
   logic [31:0] src1, src2, result;
   logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
   logic [2:0]  op4;
   logic [31:0] src1_4, src2_4, result4;
`ifdef ALU_FLAGS_EN
   logic        flag_zero, flag_carry, flag_zero4, flag_carry4;
`endif

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(32), .MUL_STEP(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy)
`ifdef ALU_FLAGS_EN
      , .flag_zero(flag_zero), .flag_carry(flag_carry)
`endif
   );

   alu_seq #(.WIDTH(32), .MUL_STEP(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .op(op4),
      .src1(src1_4), .src2(src2_4), .out_valid(out_valid4), .out_ready(out_ready4),
      .result(result4), .busy(busy4)
`ifdef ALU_FLAGS_EN
      , .flag_zero(flag_zero4), .flag_carry(flag_carry4)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for in_ready, present one request for one cycle, then scramble operands.
   task automatic accept_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", 32'(in_ready), 32'd1);
      op = o; src1 = a; src2 = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      src1 = $urandom;
      src2 = $urandom;
   endtask

   // Single-cycle op with out_ready=1: result one cycle after accept, drained the next.
   task automatic op_simple(input string tag, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
      accept_op(o, a, b);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk(tag, result, exp);
      @(negedge clk);
      chk({tag, "_drain"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int n, nbusy, nrdy;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; src1 = '0; src2 = '0;
      in_valid4 = 1'b0; out_ready4 = 1'b1; op4 = 3'd0; src1_4 = '0; src2_4 = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // ADD wrap with carry out
      accept_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
      chk("add_valid", 32'(out_valid), 32'd1);
      chk("add_result", result, 32'h0000_0001);
      chk("add_in_ready", 32'(in_ready), 32'd0);
`ifdef ALU_FLAGS_EN
      chk("add_carry", 32'(flag_carry), 32'd1);
      chk("add_zero", 32'(flag_zero), 32'd0);
`endif
      @(negedge clk);
      chk("add_drained", 32'(out_valid), 32'd0);
      chk("add_idle", 32'(in_ready), 32'd1);

      op_simple("sll", 3'd3, 32'h1, 32'h25, 32'h20);
      op_simple("bge_lt", 3'd2, 32'd3, 32'd7, 32'd0);
      op_simple("bge_eq", 3'd2, 32'd7, 32'd7, 32'd1);
      op_simple("srl", 3'd5, 32'h8000_0000, 32'h3F, 32'h1);
      op_simple("and", 3'd6, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
      op_simple("or", 3'd7, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
      op_simple("sub_wrap", 3'd4, 32'd0, 32'd1, 32'hFFFF_FFFF);

      // MUL, one bit per cycle
      accept_op(3'd1, 32'h0001_2345, 32'h0000_0100);
      n = 1; nbusy = 0; nrdy = 0;
      while (!out_valid && n < 100) begin
         if (busy) nbusy++;
         if (in_ready) nrdy++;
         @(negedge clk);
         n++;
      end
      chk("mul_latency", 32'(n), 32'd33);
      chk("mul_busy_cycles", 32'(nbusy), 32'd32);
      chk("mul_in_ready_low", 32'(nrdy), 32'd0);
      chk("mul_result", result, 32'h0123_4500);
      @(negedge clk);
      chk("mul_drained", 32'(in_ready), 32'd1);

      // MUL, four bits per cycle
      op4 = 3'd1; src1_4 = 32'h0001_2345; src2_4 = 32'h0000_0100; in_valid4 = 1'b1;
      @(negedge clk);
      in_valid4 = 1'b0; src1_4 = $urandom; src2_4 = $urandom;
      n = 1; nbusy = 0;
      while (!out_valid4 && n < 100) begin
         if (busy4) nbusy++;
         @(negedge clk);
         n++;
      end
      chk("mul4_latency", 32'(n), 32'd9);
      chk("mul4_busy_cycles", 32'(nbusy), 32'd8);
      chk("mul4_result", result4, 32'h0123_4500);
      @(negedge clk);

      // Back-pressure: result held, second request ignored
      out_ready = 1'b0;
      accept_op(3'd4, 32'd5, 32'd5);
      for (int i = 0; i < 10; i++) begin
         chk("bp_result", result, 32'd0);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
`ifdef ALU_FLAGS_EN
         chk("bp_zero", 32'(flag_zero), 32'd1);
`endif
         op = 3'd0; src1 = 32'd9; src2 = 32'd9; in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_drained", 32'(out_valid), 32'd0);
      chk("bp_idle", 32'(in_ready), 32'd1);
      chk("bp_ignored", result, 32'd0);

      // Reset in the middle of a multiply
      op_simple("add_pre", 3'd0, 32'd3, 32'd4, 32'd7);
      accept_op(3'd1, 32'h0001_2345, 32'h0000_0100);
      n = 1;
      while (n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_result", result, 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      op_simple("add_after_rst", 3'd0, 32'd1, 32'd1, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
